seq_mult32: RTL and testbench
=============================

// Module: seq_mult32
// PURPOSE
//  Sequential unsigned 32x32 shift-and-add multiplier. Upstream stage of RCA64: it
//  drives RCA64's a/b/carryInput every RUN cycle and registers RCA64's sum.
//  One partial product is added per cycle. Result is 64 bits, held until the next accepted start.
// PARAMETERS
//  WIDTH       32  operand width. Only 32 is supported, because RCA64 is a fixed 64-bit adder.
//  EARLY_EXIT  0   1 = finish as soon as the remaining multiplier bits are all zero.
// PORTS
//  clk      in   1   single clock; all state updates on posedge clk
//  rst      in   1   synchronous, active-high reset
//  start    in   1   request; sampled only while busy=0
//  a        in   32  multiplicand, captured on an accepted start
//  b        in   32  multiplier, captured on an accepted start
//  busy     out  1   high while an operation is in progress
//  done     out  1   one-cycle pulse when product is valid
//  product  out  64  a*b; holds its value until the next accepted start
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, product=0, all internal regs=0.
//  Reset has priority over everything else. Reset mid-RUN aborts the operation with no done pulse.
//  FSM states: IDLE, RUN.
//  IDLE:
//   - start=1 at edge k captures the operands: mcand={32'b0,a}, mplier=b, acc=0, cnt=0.
//   - Then state=RUN and busy=1 from edge k.
//   - product is held until the end of the new operation.
//  RUN (one iteration per edge):
//   - RCA64 inputs: a=acc, b=mcand, carryInput=0.
//   - If mplier[0]=1, acc<=sum; otherwise acc is held.
//   - Then mcand<<=1, mplier>>=1, cnt<=cnt+1.
//  Termination, EARLY_EXIT=0:
//   - Ends on the edge where cnt==31, i.e. edge k+32.
//   - That edge: product<=final acc value (including that cycle's add), done=1, busy=0, state=IDLE.
//  Termination, EARLY_EXIT=1:
//   - Ends on the first RUN edge where (mplier>>1)==0.
//   - So b=0 or b=1 finish at edge k+1. Otherwise the end is at edge k + (index of b's MSB set bit) + 1.
//  Timing:
//   - done is high for exactly one cycle, then returns to 0.
//   - busy is never high in the same cycle as done.
//  start handling:
//   - start while busy=1 is ignored; operands are not re-captured.
//   - start=1 in the done cycle is accepted, giving a back-to-back operation with no idle cycle.
//  Width rules:
//   - Unsigned only.
//   - RCA64 carryOutput is unused and must be 0 on every RUN cycle. The bench asserts this.
//   - mcand bits shifted past bit 63 are dropped (cannot occur for 32-bit a).
//  a and b may change freely while busy; they are not sampled then.
// TESTING
//  1 a=3, b=5, start at k -> busy k+1..k+32; done=1 in cycle after edge k+32; product=64'd15.
//  2 a=b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001; carryOutput stays 0 on all 32 iterations.
//  3 start a=7,b=9, then start a=2,b=2 at iteration 5 -> second start ignored; product=63, one done pulse only.
//  4 a=1000, b=1000, rst=1 at iteration 10 -> next cycle busy=0, done=0, product=0, no done pulse;
//    a later start a=6,b=7 gives 42.
//  5 Back-to-back: start a=10,b=10 held high through the done cycle with a=4,b=4 in that cycle ->
//    first done gives product=100; the second op is accepted in that same cycle; product=16 after another 32 cycles.
//  6 EARLY_EXIT=1: b=0 -> done after 1 RUN cycle, product=0; a=5,b=1 -> 1 cycle, 5;
//    a=3,b=32'h80000000 -> 32 cycles, 64'h180000000.

Source files
------------

// File: rtl/seq_mult32_if.sv
// seq_mult32_if: start/operand/result bundle for the sequential multiplier.
//   start    requester -> multiplier   begin an operation (honoured only when idle)
//   a, b     requester -> multiplier   multiplicand / multiplier operands
//   busy     multiplier -> requester   operation in progress
//   done     multiplier -> requester   one-cycle pulse, product valid
//   product  multiplier -> requester   a*b, held until the next accepted start
interface seq_mult32_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/seq_mult32.sv
// seq_mult32: unsigned shift-and-add multiplier, one partial product per clock.
// A fixed 64-bit ripple-carry adder (rca64) sums the accumulator and the shifted
// multiplicand every RUN cycle; the multiplier registers its sum.
//   clk      clock, all state changes on the rising edge
//   rst      synchronous, active-high reset
//   mIf      slave side of seq_mult32_if (start, a, b -> busy, done, product)
// Parameters: WIDTH (only 32 is meaningful, the adder is fixed at 64 bits),
//             EARLY_EXIT (1 = stop once the remaining multiplier bits are zero).
//
// state | meaning
// IDLE  | waiting for start; product holds the last result
// RUN   | one shift-and-add iteration per clock

module rca64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        carryInput,
   output logic [63:0] sum,
   output logic        carryOutput
);
   assign {carryOutput, sum} = {1'b0, a} + {1'b0, b} + {64'b0, carryInput};
endmodule

module seq_mult32 #(
   parameter int WIDTH      = 32,
   parameter int EARLY_EXIT = 0
) (
   input  logic          clk,
   input  logic          rst,
   seq_mult32_if.slave   mIf
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state, stateNext;
   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   productReg;
   logic                 doneReg;
   logic [63:0]          sum;
   logic                 carryOut;
   logic                 finish;
   logic [2*WIDTH-1:0]   accNext;

   rca64 uAdder (
      .a           (acc),
      .b           (mcand),
      .carryInput  (1'b0),
      .sum         (sum),
      .carryOutput (carryOut)
   );

   // Last iteration: fixed count, or (optionally) no set multiplier bits left above bit 0.
   always_comb begin
      finish  = 1'b0;
      accNext = acc;
      if (mplier[0]) begin
         accNext = sum;
      end
      if (cnt == CW'(WIDTH - 1)) begin
         finish = 1'b1;
      end
      if ((EARLY_EXIT != 0) && (mplier[WIDTH-1:1] == '0)) begin
         finish = 1'b1;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (mIf.start) stateNext = RUN;
         RUN:  if (finish)    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand      <= '0;
         mplier     <= '0;
         acc        <= '0;
         cnt        <= '0;
         productReg <= '0;
         doneReg    <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         case (state)
            IDLE: begin
               if (mIf.start) begin
                  mcand  <= {{WIDTH{1'b0}}, mIf.a};
                  mplier <= mIf.b;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               acc    <= accNext;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (finish) begin
                  productReg <= accNext;
                  doneReg    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // The accumulator can never exceed 64 bits for 32-bit operands.
   always_ff @(posedge clk) begin
      if (!rst && state == RUN) begin
         assert (!carryOut);
      end
   end

   assign mIf.busy    = (state == RUN);
   assign mIf.done    = doneReg;
   assign mIf.product = productReg;
endmodule

// File: tb/tb_seq_mult32.sv
module tb_seq_mult32;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] aIn = '0;
   logic [31:0] bIn = '0;

   int nChecks = 0;
   int nPass   = 0;
   int carryErr0 = 0, carryErr1 = 0;
   int overlapErr = 0;

   always #5 clk = ~clk;

   seq_mult32_if #(.WIDTH(32)) if0 ();
   seq_mult32_if #(.WIDTH(32)) if1 ();

   assign if0.start = start;
   assign if0.a     = aIn;
   assign if0.b     = bIn;
   assign if1.start = start;
   assign if1.a     = aIn;
   assign if1.b     = bIn;

   seq_mult32 #(.WIDTH(32), .EARLY_EXIT(0)) dut0 (.clk(clk), .rst(rst), .mIf(if0));
   seq_mult32 #(.WIDTH(32), .EARLY_EXIT(1)) dut1 (.clk(clk), .rst(rst), .mIf(if1));

   always @(negedge clk) begin
      if (!rst && if0.busy && dut0.carryOut) carryErr0++;
      if (!rst && if1.busy && dut1.carryOut) carryErr1++;
      if ((if0.busy && if0.done) || (if1.busy && if1.done)) overlapErr++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: the product is plain arithmetic; early-exit latency is the
   // position of the highest set multiplier bit plus one (at least one cycle).
   function automatic logic [63:0] refProd(input logic [31:0] a, input logic [31:0] b);
      return {32'b0, a} * {32'b0, b};
   endfunction

   function automatic int refLatEarly(input logic [31:0] b);
      int msb = 0;
      for (int i = 0; i < 32; i++) if (b[i]) msb = i;
      return msb + 1;
   endfunction

   task automatic watch(input int maxCyc,
                        output int nDone0, output int first0, output logic [63:0] p0,
                        output int nDone1, output int first1, output logic [63:0] p1);
      nDone0 = 0; first0 = 0; p0 = '0;
      nDone1 = 0; first1 = 0; p1 = '0;
      for (int i = 1; i <= maxCyc; i++) begin
         @(posedge clk); #1;
         if (if0.done) begin
            nDone0++;
            if (first0 == 0) begin first0 = i; p0 = if0.product; end
         end
         if (if1.done) begin
            nDone1++;
            if (first1 == 0) begin first1 = i; p1 = if1.product; end
         end
      end
   endtask

   task automatic doOp(input string tag, input logic [31:0] a, input logic [31:0] b);
      int nd0, f0, nd1, f1;
      logic [63:0] p0, p1, expP;
      expP  = refProd(a, b);
      start = 1'b1; aIn = a; bIn = b;
      @(posedge clk); #1;
      start = 1'b0; aIn = $urandom; bIn = $urandom;
      chk({tag, ".busy0"}, 64'(if0.busy), 64'd1);
      chk({tag, ".busy1"}, 64'(if1.busy), 64'd1);
      watch(34, nd0, f0, p0, nd1, f1, p1);
      chk({tag, ".pulses0"}, 64'(nd0), 64'd1);
      chk({tag, ".lat0"},    64'(f0),  64'd32);
      chk({tag, ".prod0"},   p0,       expP);
      chk({tag, ".pulses1"}, 64'(nd1), 64'd1);
      chk({tag, ".lat1"},    64'(f1),  64'(refLatEarly(b)));
      chk({tag, ".prod1"},   p1,       expP);
      chk({tag, ".hold0"},   if0.product, expP);
      chk({tag, ".hold1"},   if1.product, expP);
   endtask

   task automatic doReset();
      rst = 1'b1; start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int nd0, f0, nd1, f1;
      logic [63:0] p0, p1;
      logic [31:0] ra, rb;

      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy0", 64'(if0.busy), 64'd0);
      chk("rst.done0", 64'(if0.done), 64'd0);
      chk("rst.prod0", if0.product,   64'd0);
      chk("rst.busy1", 64'(if1.busy), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      doOp("small",  32'd3, 32'd5);
      doOp("allOnes", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      doOp("bZero",  32'd1234, 32'd0);
      doOp("bOne",   32'd5, 32'd1);
      doOp("bMsb",   32'd3, 32'h8000_0000);
      for (int n = 0; n < 20; n++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         doOp($sformatf("rand%0d", n), ra, rb);
      end

      // Start while busy is ignored.
      start = 1'b1; aIn = 32'd7; bIn = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      start = 1'b1; aIn = 32'd2; bIn = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      watch(40, nd0, f0, p0, nd1, f1, p1);
      chk("ignore.pulses", 64'(nd0), 64'd1);
      chk("ignore.lat",    64'(f0),  64'd26);
      chk("ignore.prod",   p0,       64'd63);
      doReset();

      // Reset mid-operation aborts without a done pulse.
      start = 1'b1; aIn = 32'd1000; bIn = 32'd1000;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort.busy", 64'(if0.busy), 64'd0);
      chk("abort.done", 64'(if0.done), 64'd0);
      chk("abort.prod", if0.product,   64'd0);
      rst = 1'b0;
      watch(40, nd0, f0, p0, nd1, f1, p1);
      chk("abort.pulses", 64'(nd0), 64'd0);
      doOp("afterAbort", 32'd6, 32'd7);

      // Back-to-back: start held through the done cycle.
      start = 1'b1; aIn = 32'd10; bIn = 32'd10;
      @(posedge clk); #1;
      aIn = 32'd4; bIn = 32'd4;
      watch(33, nd0, f0, p0, nd1, f1, p1);
      start = 1'b0;
      chk("b2b.pulses1st", 64'(nd0), 64'd1);
      chk("b2b.lat1st",    64'(f0),  64'd32);
      chk("b2b.prod1st",   p0,       64'd100);
      chk("b2b.accepted",  64'(if0.busy), 64'd1);
      chk("b2b.held",      if0.product,   64'd100);
      watch(40, nd0, f0, p0, nd1, f1, p1);
      chk("b2b.pulses2nd", 64'(nd0), 64'd1);
      chk("b2b.lat2nd",    64'(f0),  64'd32);
      chk("b2b.prod2nd",   p0,       64'd16);
      doReset();

      chk("carry0",  64'(carryErr0),  64'd0);
      chk("carry1",  64'(carryErr1),  64'd0);
      chk("overlap", 64'(overlapErr), 64'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
